// File: rtl/uart_mmio_if.sv
// Data-RAM-style bus between the core (master) and the console peripheral (slave).
interface uart_mmio_if;
  logic [63:0] bus_addr;
  logic        bus_r_ena;
  logic        bus_w_ena;
  logic [63:0] bus_w_mask;
  logic [63:0] bus_w_data;
  logic [63:0] bus_r_data;
  logic        bus_sel;

  modport master (
    output bus_addr, bus_r_ena, bus_w_ena, bus_w_mask, bus_w_data,
    input  bus_r_data, bus_sel
  );
  modport slave (
    input  bus_addr, bus_r_ena, bus_w_ena, bus_w_mask, bus_w_data,
    output bus_r_data, bus_sel
  );
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped console UART: paced TX FIFO and polled RX buffer behind an 8-byte window.
// Optional UART_LOOPBACK_EN routes drained TX bytes into RX and silences the external channel.
module uart_mmio #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_1000_0000,
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 4,
  parameter int          TX_DIV    = 4,
  parameter int          RX_POLL   = 16
) (
  input  logic       clk,
  input  logic       reset,
  uart_mmio_if.slave bus,
  output logic       uart_out_valid,
  output logic [7:0] uart_out_ch,
  output logic       uart_in_valid,
  input  logic [7:0] uart_in_ch
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TCW = (TX_DIV  > 1) ? $clog2(TX_DIV)  : 1;
  localparam int RCW = (RX_POLL > 1) ? $clog2(RX_POLL) : 1;
  localparam logic [TCW-1:0] TX_LOAD = TCW'(TX_DIV - 1);
  localparam logic [RCW-1:0] RX_LOAD = RCW'(RX_POLL - 1);

  logic [7:0]     tx_mem [TX_DEPTH];
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [TAW:0]   tx_wp, tx_rp;
  logic [RAW:0]   rx_wp, rx_rp;
  logic [TCW-1:0] tx_cnt;
  logic [RCW-1:0] rx_cnt;
  logic           ovf;

  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic       rd, wr, tx_pop, tx_push, ovf_set, rx_pop, rx_push;
  logic [7:0] rx_push_ch, rbr, lsr;
  logic       unused_bits;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign tx_empty = tx_wp == tx_rp;
  assign tx_full  = (tx_wp[TAW] != tx_rp[TAW]) && (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
  assign rx_empty = rx_wp == rx_rp;
  assign rx_full  = (rx_wp[RAW] != rx_rp[RAW]) && (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);

  assign bus.bus_sel = bus.bus_addr[63:3] == BASE_ADDR[63:3];
  assign rd = bus.bus_sel && bus.bus_r_ena;
  assign wr = bus.bus_sel && bus.bus_w_ena && (bus.bus_addr[2:0] == 3'd0) &&
              (bus.bus_w_mask[7:0] == 8'hFF);

`ifdef UART_LOOPBACK_EN
  // Drain stalls at count zero until RX has room.
  assign tx_pop        = !tx_empty && (tx_cnt == '0) && !rx_full;
  assign uart_in_valid = 1'b0;
  assign rx_push       = tx_pop;
  assign rx_push_ch    = tx_mem[tx_rp[TAW-1:0]];
  assign unused_bits   = ^{bus.bus_w_mask[63:8], bus.bus_w_data[63:8], uart_in_ch};
`else
  assign tx_pop        = !tx_empty && (tx_cnt == '0);
  assign uart_in_valid = (rx_cnt == '0) && !rx_full;
  assign rx_push       = uart_in_valid && (uart_in_ch != 8'hFF);
  assign rx_push_ch    = uart_in_ch;
  assign unused_bits   = ^{bus.bus_w_mask[63:8], bus.bus_w_data[63:8]};
`endif

  // A drain pop frees a slot in the same edge, so a push into a full FIFO still lands.
  assign tx_push = wr && (!tx_full || tx_pop);
  assign ovf_set = wr && tx_full && !tx_pop;
  assign rx_pop  = rd && !rx_empty;

  assign rbr = rx_empty ? 8'd0 : rx_mem[rx_rp[RAW-1:0]];
  assign lsr = {1'b0, tx_empty && !uart_out_valid, !tx_full, 3'b000, ovf, !rx_empty};
  assign bus.bus_r_data = rd ? {16'd0, lsr, 32'd0, rbr} : 64'd0;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= bus.bus_w_data[7:0];
    if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= rx_push_ch;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wp          <= '0;
      tx_rp          <= '0;
      rx_wp          <= '0;
      rx_rp          <= '0;
      tx_cnt         <= TX_LOAD;
      rx_cnt         <= RX_LOAD;
      ovf            <= 1'b0;
      uart_out_valid <= 1'b0;
      uart_out_ch    <= 8'd0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;

      if (tx_empty || tx_pop)  tx_cnt <= TX_LOAD;
      else if (tx_cnt != '0)   tx_cnt <= tx_cnt - 1'b1;

      rx_cnt <= (rx_cnt == '0) ? RX_LOAD : rx_cnt - 1'b1;
      // Every window read clears the sticky bit; a new overflow at the same edge wins.
      ovf    <= ovf_set || (ovf && !rd);

`ifdef UART_LOOPBACK_EN
      uart_out_valid <= 1'b0;
`else
      uart_out_valid <= tx_pop;
      if (tx_pop) uart_out_ch <= tx_mem[tx_rp[TAW-1:0]];
`endif
    end
  end
endmodule
